fc_stream_layer: RTL and testbench

//  Fully-connected stage fed directly by the pooled convolution output stream (6x6 = 36 words, 36-bit, unsigned).

---
 rtl/fc_stream_layer.sv | 153 +++++++++++++++
 tb/tb_fc_stream_layer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fc_stream_layer.sv
// Fully-connected stage: serially loaded N_OUT x N_IN weight matrix. It runs N_OUT parallel
// dot products over one feature frame, then emits the results one neuron per cycle.
//
// state  | meaning
// IDLE   | no weights loaded since reset
// LOADW  | storing weight beats at w_addr_q
// READY  | weights complete, waiting for first feature beat or a reload
// ACCUM  | accumulating feature beats into all neurons in parallel
// OUTPUT | emitting acc_q[0..N_OUT-1], one per cycle
module fc_stream_layer #(
  parameter int IN_W  = 36,
  parameter int WT_W  = 16,
  parameter int N_IN  = 36,
  parameter int N_OUT = 4,
  parameter int ACC_W = IN_W + WT_W + 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       w_valid_i,
  input  logic [WT_W-1:0]            w_data_i,
  input  logic                       in_valid_i,
  input  logic [IN_W-1:0]            in_data_i,
  output logic                       out_valid_o,
  output logic [$clog2(N_OUT)-1:0]   out_idx_o,
  output logic [ACC_W-1:0]           out_data_o,
  output logic                       weights_ok_o,
  output logic                       busy_o,
  output logic                       err_o
);

  localparam int N_W   = N_IN * N_OUT;
  localparam int WA_W  = $clog2(N_W);
  localparam int CNT_W = $clog2(N_IN);
  localparam int IDX_W = $clog2(N_OUT);

  typedef enum logic [2:0] {IDLE, LOADW, READY, ACCUM, OUTPUT} state_t;

  state_t             state_q;
  logic [WT_W-1:0]    wmem_q [N_W];
  logic [ACC_W-1:0]   acc_q  [N_OUT];
  logic [WA_W-1:0]    w_addr_q;
  logic [CNT_W-1:0]   in_cnt_q;
  logic [IDX_W-1:0]   out_cnt_q;
  logic               out_valid_q;
  logic [IDX_W-1:0]   out_idx_q;
  logic [ACC_W-1:0]   out_data_q;
  logic               weights_ok_q;
  logic               busy_q;
  logic               err_q;

  logic [CNT_W-1:0]   feat_sel;
  logic [ACC_W-1:0]   prod [N_OUT];

  // The first beat of a frame arrives in READY, when in_cnt_q is still 0.
  always_comb begin
    feat_sel = (state_q == ACCUM) ? in_cnt_q : '0;
    for (int k = 0; k < N_OUT; k++) begin
      prod[k] = ACC_W'(in_data_i) * ACC_W'(wmem_q[WA_W'(k * N_IN) + WA_W'(feat_sel)]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      for (int i = 0; i < N_W; i++) wmem_q[i] <= '0;
      for (int k = 0; k < N_OUT; k++) acc_q[k] <= '0;
      w_addr_q     <= '0;
      in_cnt_q     <= '0;
      out_cnt_q    <= '0;
      out_valid_q  <= 1'b0;
      out_idx_q    <= '0;
      out_data_q   <= '0;
      weights_ok_q <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid_i) err_q <= 1'b1;
          if (w_valid_i) begin
            wmem_q[0] <= w_data_i;
            w_addr_q  <= WA_W'(1);
            state_q   <= LOADW;
          end
        end
        LOADW: begin
          if (in_valid_i) err_q <= 1'b1;
          if (w_valid_i) begin
            wmem_q[w_addr_q] <= w_data_i;
            if (w_addr_q == WA_W'(N_W - 1)) begin
              w_addr_q     <= '0;
              weights_ok_q <= 1'b1;
              state_q      <= READY;
            end else begin
              w_addr_q <= w_addr_q + 1'b1;
            end
          end
        end
        READY: begin
          if (in_valid_i) begin
            // A simultaneous weight beat is dropped; the frame takes priority.
            if (w_valid_i) err_q <= 1'b1;
            for (int k = 0; k < N_OUT; k++) acc_q[k] <= prod[k];
            in_cnt_q <= CNT_W'(1);
            busy_q   <= 1'b1;
            state_q  <= ACCUM;
          end else if (w_valid_i) begin
            weights_ok_q <= 1'b0;
            wmem_q[0]    <= w_data_i;
            w_addr_q     <= WA_W'(1);
            state_q      <= LOADW;
          end
        end
        ACCUM: begin
          if (w_valid_i) err_q <= 1'b1;
          if (in_valid_i) begin
            for (int k = 0; k < N_OUT; k++) acc_q[k] <= acc_q[k] + prod[k];
            if (in_cnt_q == CNT_W'(N_IN - 1)) begin
              in_cnt_q  <= '0;
              out_cnt_q <= '0;
              state_q   <= OUTPUT;
            end else begin
              in_cnt_q <= in_cnt_q + 1'b1;
            end
          end
        end
        OUTPUT: begin
          if (in_valid_i || w_valid_i) err_q <= 1'b1;
          out_valid_q <= 1'b1;
          out_idx_q   <= out_cnt_q;
          out_data_q  <= acc_q[out_cnt_q];
          if (out_cnt_q == IDX_W'(N_OUT - 1)) begin
            out_cnt_q <= '0;
            busy_q    <= 1'b0;
            state_q   <= READY;
          end else begin
            out_cnt_q <= out_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid_o  = out_valid_q;
  assign out_idx_o    = out_idx_q;
  assign out_data_o   = out_data_q;
  assign weights_ok_o = weights_ok_q;
  assign busy_o       = busy_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_fc_stream_layer.sv
// Directed bench for fc_stream_layer: a reference dot-product model fills a scoreboard,
// and each output beat is popped from it and compared.
module tb_fc_stream_layer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         w_valid;
  logic [15:0]  w_data;
  logic         in_valid;
  logic [35:0]  in_data;
  logic         out_valid;
  logic [1:0]   out_idx;
  logic [57:0]  out_data;
  logic         weights_ok;
  logic         busy;
  logic         err;

  int checks = 0;
  int errors = 0;

  logic [15:0]  wm [144];
  logic [35:0]  xs [36];
  logic [59:0]  sb [$];

  fc_stream_layer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .w_valid_i    (w_valid),
    .w_data_i     (w_data),
    .in_valid_i   (in_valid),
    .in_data_i    (in_data),
    .out_valid_o  (out_valid),
    .out_idx_o    (out_idx),
    .out_data_o   (out_data),
    .weights_ok_o (weights_ok),
    .busy_o       (busy),
    .err_o        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock, sampled 1 time unit after the edge; any output beat is checked against the scoreboard.
  task automatic tick();
    logic [59:0] e;
    @(posedge clk);
    #1;
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", 64'(out_valid), 64'd0);
      end else begin
        e = sb.pop_front();
        chk("out_beat", 64'({out_idx, out_data}), 64'(e));
      end
    end
  endtask

  function automatic logic [57:0] dot(input int k);
    logic [57:0] s = '0;
    for (int i = 0; i < 36; i++) s += 58'(xs[i]) * 58'(wm[k*36+i]);
    return s;
  endfunction

  // mode 0: all ones, 1: neuron k gets k+1, 2: full scale
  task automatic load_weights(input int mode, input int n);
    logic [15:0] wd;
    for (int a = 0; a < n; a++) begin
      wd = (mode == 0) ? 16'd1 : (mode == 1) ? 16'(a / 36 + 1) : 16'hFFFF;
      if (n == 144) wm[a] = wd;
      w_valid = 1'b1;
      w_data  = wd;
      tick();
    end
    w_valid = 1'b0;
  endtask

  // mode 0: x=i+1, 1: x=2, 2: full scale, 3: x=3
  task automatic set_x(input int mode);
    for (int i = 0; i < 36; i++)
      xs[i] = (mode == 0) ? 36'(i + 1) : (mode == 1) ? 36'd2 :
              (mode == 2) ? 36'hF_FFFF_FFFF : 36'd3;
  endtask

  task automatic send_beats(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = xs[i];
      tick();
      in_valid = 1'b0;
      if (i < n - 1) repeat (gap - 1) tick();
    end
  endtask

  task automatic run_frame(input int xm, input int gap);
    logic [1:0] kk;
    set_x(xm);
    for (int k = 0; k < 4; k++) begin
      kk = 2'(k);
      sb.push_back({kk, dot(k)});
    end
    send_beats(36, gap);
    tick();
    chk("lat_valid", 64'(out_valid), 64'd1);
    chk("lat_idx", 64'(out_idx), 64'd0);
    chk("busy_out", 64'(busy), 64'd1);
    repeat (3) tick();
    tick();
    chk("valid_drop", 64'(out_valid), 64'd0);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    chk("busy_idle", 64'(busy), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; w_valid = 1'b0; w_data = '0; in_valid = 1'b0; in_data = '0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_idx", 64'(out_idx), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_weights_ok", 64'(weights_ok), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    #13 rst_n = 1'b1;
    tick();

    // 1: unit weights, x=1..36 contiguous -> 666 on every neuron
    load_weights(0, 144);
    chk("t1_weights_ok", 64'(weights_ok), 64'd1);
    run_frame(0, 1);
    chk("t1_hold_data", 64'(out_data), 64'd666);
    chk("t1_hold_idx", 64'(out_idx), 64'd3);

    // 2: W[k]=k+1, x=2 every third cycle -> 72,144,216,288; reload from READY
    load_weights(1, 144);
    run_frame(1, 3);
    chk("t2_err", 64'(err), 64'd0);

    // 3: full scale, no truncation
    load_weights(2, 144);
    run_frame(2, 1);
    chk("t3_last_data", 64'(out_data), 64'(58'd36 * 58'h0F_FFFF_FFFF * 58'd65535));
    chk("t3_err", 64'(err), 64'd0);

    // 5: back-to-back frames with unit weights; no carry-over
    load_weights(0, 144);
    run_frame(0, 1);
    run_frame(3, 1);
    chk("t5_last_data", 64'(out_data), 64'd108);
    chk("t5_err", 64'(err), 64'd0);

    // 4: partial load then a frame -> rejected
    load_weights(0, 100);
    chk("t4_weights_ok_load", 64'(weights_ok), 64'd0);
    set_x(0);
    send_beats(36, 1);
    repeat (8) tick();
    chk("t4_weights_ok", 64'(weights_ok), 64'd0);
    chk("t4_err", 64'(err), 64'd1);
    chk("t4_busy", 64'(busy), 64'd0);

    // 6: reset mid-frame
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    load_weights(0, 144);
    set_x(0);
    send_beats(20, 1);
    chk("t6_busy_pre", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_out_valid", 64'(out_valid), 64'd0);
    chk("t6_out_idx", 64'(out_idx), 64'd0);
    chk("t6_out_data", 64'(out_data), 64'd0);
    chk("t6_weights_ok", 64'(weights_ok), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_err", 64'(err), 64'd0);
    #3 rst_n = 1'b1;
    tick();
    send_beats(36, 1);
    repeat (8) tick();
    chk("t6_reject_err", 64'(err), 64'd1);
    chk("t6_reject_wok", 64'(weights_ok), 64'd0);
    load_weights(0, 144);
    run_frame(0, 1);
    chk("t6_reload_data", 64'(out_data), 64'd666);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
